// File: rtl/lif_membrane_integrator.sv
// Leaky integrate-and-fire membrane stage.
// Each accepted strobe adds the adder sum to a leaky membrane potential. When
// the potential reaches the runtime threshold, the stage emits a one-cycle
// spike, clears the membrane, and then ignores strobes for REFRACT_CYCLES
// cycles.
// Optional feature: define LIF_SATURATE_EN to clamp overflow to all-ones and
// flag it on sat. When it is undefined, overflow wraps and sat is tied low.
module lif_membrane_integrator #(
   parameter int unsigned N              = 4,
   parameter int unsigned V_WIDTH        = 8,
   parameter int unsigned LEAK_SHIFT     = 1,
   parameter int unsigned REFRACT_CYCLES = 2
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               in_valid,
   input  logic [N:0]         in_sum,
   input  logic [V_WIDTH-1:0] threshold,
   output logic               spike,
   output logic [V_WIDTH-1:0] membrane,
   output logic               refractory,
   output logic               sat
);

   localparam int unsigned CW = (REFRACT_CYCLES < 2) ? 1 : $clog2(REFRACT_CYCLES + 1);

   typedef enum logic {
      INTEGRATE = 1'b0,
      REFRACT   = 1'b1
   } state_t;

   state_t             state_q, state_d;
   logic [CW-1:0]      cnt_q, cnt_d;
   logic               spike_q, spike_d;
   logic [V_WIDTH-1:0] mem_q, mem_d;
   logic [V_WIDTH-1:0] v_leak;
   logic [V_WIDTH-1:0] v_eff;
   logic               fire;

`ifdef LIF_SATURATE_EN
   logic               sat_q, sat_d;
   logic [V_WIDTH:0]   v_sum;
   logic               ovf;
`endif

   // Leak, integrate, and overflow handling for the candidate potential
   always_comb begin
      // mem - (mem >> k) never underflows, so V_WIDTH bits are enough here
      v_leak = mem_q - (mem_q >> LEAK_SHIFT);
`ifdef LIF_SATURATE_EN
      v_sum = {1'b0, v_leak} + (V_WIDTH + 1)'(in_sum);
      ovf   = v_sum[V_WIDTH];
      v_eff = ovf ? '1 : v_sum[V_WIDTH-1:0];
`else
      v_eff = v_leak + V_WIDTH'(in_sum);
`endif
      fire = (v_eff >= threshold);
   end

   // Next-state logic for the integrate/refractory FSM and its outputs
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      spike_d = 1'b0;
      mem_d   = mem_q;
`ifdef LIF_SATURATE_EN
      sat_d   = 1'b0;
`endif
      case (state_q)
         INTEGRATE: begin
            if (in_valid) begin
`ifdef LIF_SATURATE_EN
               sat_d = ovf;
`endif
               if (fire) begin
                  spike_d = 1'b1;
                  mem_d   = '0;
                  if (REFRACT_CYCLES > 0) begin
                     state_d = REFRACT;
                     cnt_d   = CW'(REFRACT_CYCLES);
                  end
               end else begin
                  mem_d = v_eff;
               end
            end
         end
         REFRACT: begin
            // The spike cycle is the first refractory cycle, so leaving at
            // count 1 gives exactly REFRACT_CYCLES cycles with refractory high
            mem_d = '0;
            cnt_d = cnt_q - CW'(1);
            if (cnt_q == CW'(1)) begin
               state_d = INTEGRATE;
            end
         end
         default: begin
            state_d = INTEGRATE;
            cnt_d   = '0;
            mem_d   = '0;
         end
      endcase
   end

   // State and output registers with asynchronous reset
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= INTEGRATE;
         cnt_q   <= '0;
         spike_q <= 1'b0;
         mem_q   <= '0;
`ifdef LIF_SATURATE_EN
         sat_q   <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         spike_q <= spike_d;
         mem_q   <= mem_d;
`ifdef LIF_SATURATE_EN
         sat_q   <= sat_d;
`endif
      end
   end

   assign spike      = spike_q;
   assign membrane   = mem_q;
   assign refractory = (state_q == REFRACT);
`ifdef LIF_SATURATE_EN
   assign sat        = sat_q;
`else
   assign sat        = 1'b0;
`endif

endmodule

// File: tb/tb_lif_membrane_integrator.sv
// Scoreboard bench for lif_membrane_integrator. It uses three instances:
// A with default parameters, B with LEAK_SHIFT=4 for overflow checks, and C
// with REFRACT_CYCLES=0. The expected values are hand-computed constants.
module tb_lif_membrane_integrator;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst_a, vld_a, sp_a, rf_a, sat_a;
   logic [4:0] sum_a;
   logic [7:0] thr_a, mem_a;
   logic       rst_b, vld_b, sp_b, rf_b, sat_b;
   logic [4:0] sum_b;
   logic [7:0] thr_b, mem_b;
   logic       rst_c, vld_c, sp_c, rf_c, sat_c;
   logic [4:0] sum_c;
   logic [7:0] thr_c, mem_c;

   lif_membrane_integrator u_a (
      .clk(clk), .reset(rst_a), .in_valid(vld_a), .in_sum(sum_a), .threshold(thr_a),
      .spike(sp_a), .membrane(mem_a), .refractory(rf_a), .sat(sat_a));

   lif_membrane_integrator #(.LEAK_SHIFT(4)) u_b (
      .clk(clk), .reset(rst_b), .in_valid(vld_b), .in_sum(sum_b), .threshold(thr_b),
      .spike(sp_b), .membrane(mem_b), .refractory(rf_b), .sat(sat_b));

   lif_membrane_integrator #(.REFRACT_CYCLES(0)) u_c (
      .clk(clk), .reset(rst_c), .in_valid(vld_c), .in_sum(sum_c), .threshold(thr_c),
      .spike(sp_c), .membrane(mem_c), .refractory(rf_c), .sat(sat_c));

   typedef struct {
      int unsigned target;
      int          id;
      logic        spike;
      logic [7:0]  mem;
      logic        refr;
      logic        sat;
      string       tag;
   } exp_t;

   exp_t        sb[$];
   int unsigned cyc = 0;
   int          n_tests = 0;
   int          n_fail = 0;

   task automatic chk(input string name, input int act, input int exp);
      n_tests++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   task automatic chk_out(input int id, input string tag, input logic es, input logic [7:0] em,
                          input logic er, input logic esat);
      logic       s, r, st;
      logic [7:0] m;
      case (id)
         0:       begin s = sp_a; m = mem_a; r = rf_a; st = sat_a; end
         1:       begin s = sp_b; m = mem_b; r = rf_b; st = sat_b; end
         default: begin s = sp_c; m = mem_c; r = rf_c; st = sat_c; end
      endcase
      chk({tag, ".spike"}, int'(s), int'(es));
      chk({tag, ".membrane"}, int'(m), int'(em));
      chk({tag, ".refractory"}, int'(r), int'(er));
      chk({tag, ".sat"}, int'(st), int'(esat));
   endtask

   // Monitor: after each rising edge, compare the outputs with every
   // expectation whose target is this cycle
   initial begin
      exp_t e;
      forever begin
         @(posedge clk);
         cyc++;
         #2;
         while (sb.size() > 0 && sb[0].target <= cyc) begin
            e = sb.pop_front();
            if (e.target < cyc) chk({e.tag, ".missed"}, int'(cyc), int'(e.target));
            else chk_out(e.id, e.tag, e.spike, e.mem, e.refr, e.sat);
         end
      end
   end

   // Drive one cycle of stimulus to instance id and queue the expected
   // outputs for the next edge. Call this at posedge+1.
   task automatic step(input int id, input logic v, input logic [4:0] s, input logic [7:0] t,
                       input logic es, input logic [7:0] em, input logic er, input logic esat,
                       input string tag);
      exp_t e;
      vld_a = 1'b0; vld_b = 1'b0; vld_c = 1'b0;
      case (id)
         0:       begin vld_a = v; sum_a = s; thr_a = t; end
         1:       begin vld_b = v; sum_b = s; thr_b = t; end
         default: begin vld_c = v; sum_c = s; thr_c = t; end
      endcase
      e.target = cyc + 1; e.id = id; e.spike = es; e.mem = em; e.refr = er; e.sat = esat;
      e.tag = tag;
      sb.push_back(e);
      @(posedge clk);
      #1;
   endtask

   // Pulse reset between edges and check that the outputs clear without a clock
   task automatic async_rst(input string tag);
      #3;
      rst_a = 1'b1;
      #1;
      chk_out(0, tag, 1'b0, 8'd0, 1'b0, 1'b0);
      #1;
      rst_a = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "timeout");
   end

   initial begin
      int unsigned ramp_b[10];
      ramp_b = '{31, 61, 89, 115, 139, 162, 183, 203, 222, 240};
      rst_a = 1'b1; rst_b = 1'b1; rst_c = 1'b1;
      vld_a = 1'b0; vld_b = 1'b0; vld_c = 1'b0;
      sum_a = '0; sum_b = '0; sum_c = '0;
      thr_a = '0; thr_b = '0; thr_c = '0;
      #2;
      chk_out(0, "por_a", 1'b0, 8'd0, 1'b0, 1'b0);
      chk_out(1, "por_b", 1'b0, 8'd0, 1'b0, 1'b0);
      @(posedge clk);
      #1;
      rst_a = 1'b0; rst_b = 1'b0; rst_c = 1'b0;

      // Integrate and fire with threshold 20, including one idle hold
      step(0, 1, 5'd10, 8'd20, 0, 8'd10, 0, 0, "int1");
      step(0, 1, 5'd10, 8'd20, 0, 8'd15, 0, 0, "int2");
      step(0, 0, 5'd10, 8'd20, 0, 8'd15, 0, 0, "hold");
      step(0, 1, 5'd10, 8'd20, 0, 8'd18, 0, 0, "int3");
      step(0, 1, 5'd10, 8'd20, 0, 8'd19, 0, 0, "int4");
      step(0, 1, 5'd10, 8'd20, 1, 8'd0,  1, 0, "fire");
      step(0, 0, 5'd0,  8'd20, 0, 8'd0,  1, 0, "refr2");
      step(0, 0, 5'd0,  8'd20, 0, 8'd0,  0, 0, "refr_end");

      // Strobes every cycle: the two strobes during refractory are dropped
      step(0, 1, 5'd31, 8'd20, 1, 8'd0, 1, 0, "drop_fire1");
      step(0, 1, 5'd31, 8'd20, 0, 8'd0, 1, 0, "drop1");
      step(0, 1, 5'd31, 8'd20, 0, 8'd0, 0, 0, "drop2");
      step(0, 1, 5'd31, 8'd20, 1, 8'd0, 1, 0, "drop_fire2");
      step(0, 0, 5'd0,  8'd20, 0, 8'd0, 1, 0, "drop_r");
      step(0, 0, 5'd0,  8'd20, 0, 8'd0, 0, 0, "drop_end");

      // Asynchronous reset in the middle of the stream
      step(0, 1, 5'd10, 8'd20, 0, 8'd10, 0, 0, "pre_rst");
      async_rst("rst_mid");
      step(0, 1, 5'd10, 8'd20, 0, 8'd10, 0, 0, "post_rst");

      // Reset during the first refractory cycle; the next strobe is accepted
      step(0, 1, 5'd31, 8'd20, 1, 8'd0, 1, 0, "fire_r");
      async_rst("rst_refr");
      step(0, 1, 5'd10, 8'd20, 0, 8'd10, 0, 0, "after_rrst");

      // Overflow with LEAK_SHIFT=4 and threshold 255
      for (int i = 0; i < 10; i++)
         step(1, 1, 5'd31, 8'd255, 0, 8'(ramp_b[i]), 0, 0, $sformatf("ramp%0d", i));
`ifdef LIF_SATURATE_EN
      step(1, 1, 5'd31, 8'd255, 1, 8'd0, 1, 1, "ovf_sat");
      step(1, 0, 5'd0,  8'd255, 0, 8'd0, 1, 0, "ovf_sat_r");
      step(1, 0, 5'd0,  8'd255, 0, 8'd0, 0, 0, "ovf_sat_end");
`else
      step(1, 1, 5'd31, 8'd255, 0, 8'd0,  0, 0, "ovf_wrap");
      step(1, 1, 5'd31, 8'd255, 0, 8'd31, 0, 0, "ovf_wrap_next");
`endif

      // Threshold 0 and no refractory period: every strobe fires
      step(2, 1, 5'd0,  8'd0,   1, 8'd0, 0, 0, "t0_a");
      step(2, 1, 5'd0,  8'd0,   1, 8'd0, 0, 0, "t0_b");
      step(2, 1, 5'd5,  8'd0,   1, 8'd0, 0, 0, "t0_c");
      step(2, 0, 5'd0,  8'd0,   0, 8'd0, 0, 0, "t0_idle");
      step(2, 1, 5'd7,  8'd100, 0, 8'd7, 0, 0, "r0_int");

      vld_a = 1'b0; vld_b = 1'b0; vld_c = 1'b0;
      repeat (2) @(posedge clk);
      #3;
      chk("sb_drained", sb.size(), 0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
